// File: rtl/conv_pass_sequencer_pkg.sv
// conv_seq_pkg: shared state encoding, default widths and config record for the pass sequencer
// Contents: seq_state_t (FSM states), *_DEF width defaults, seq_cfg_t (one layer configuration).
package conv_seq_pkg;
  localparam int FILT_ADDR_LEN_DEF = 4;
  localparam int IF_ADDR_LEN_DEF = 5;
  localparam int PASS_W_DEF = 8;
  localparam int TMO_W_DEF = 16;
  typedef enum logic [2:0] {IDLE, WAIT_DATA, START, RUN, DRAIN, NEXT, DONE} seq_state_t;
  typedef struct packed {
    logic [PASS_W_DEF-1:0] passes;
    logic [FILT_ADDR_LEN_DEF-1:0] filt_len;
    logic [IF_ADDR_LEN_DEF-1:0] stride_len;
    logic [1:0] mode;
    logic accumulate;
  } seq_cfg_t;
endpackage

// File: rtl/conv_pass_sequencer_if.sv
// conv_pass_sequencer_if: host/config, FIFO-flag and conv-top control signals of the sequencer
// Modports: master = sequencer (drives cfg_ready and all control/status outputs),
//           slave  = environment (host config, abort, FIFO flags, pass_done).
interface conv_pass_sequencer_if
  import conv_seq_pkg::*;
#(
  parameter int FILT_ADDR_LEN = FILT_ADDR_LEN_DEF,
  parameter int IF_ADDR_LEN = IF_ADDR_LEN_DEF,
  parameter int PASS_W = PASS_W_DEF
);
  logic cfg_valid;
  logic cfg_ready;
  logic [PASS_W-1:0] cfg_passes;
  logic [FILT_ADDR_LEN-1:0] cfg_filt_len;
  logic [IF_ADDR_LEN-1:0] cfg_stride_len;
  logic [1:0] cfg_mode;
  logic cfg_accumulate;
  logic abort;
  logic if_empty;
  logic filter_empty;
  logic outbuf_empty;
  logic outbuf_full;
  logic pass_done;
  logic start;
  logic [1:0] mode;
  logic [FILT_ADDR_LEN-1:0] filt_len;
  logic [IF_ADDR_LEN-1:0] stride_len;
  logic psum_mode;
  logic outbuf_ren;
  logic [PASS_W-1:0] pass_idx;
  logic busy;
  logic seq_done;
  logic err_timeout;
  modport master (
    input cfg_valid, cfg_passes, cfg_filt_len, cfg_stride_len, cfg_mode, cfg_accumulate,
    input abort, if_empty, filter_empty, outbuf_empty, outbuf_full, pass_done,
    output cfg_ready, start, mode, filt_len, stride_len, psum_mode, outbuf_ren,
    output pass_idx, busy, seq_done, err_timeout
  );
  modport slave (
    output cfg_valid, cfg_passes, cfg_filt_len, cfg_stride_len, cfg_mode, cfg_accumulate,
    output abort, if_empty, filter_empty, outbuf_empty, outbuf_full, pass_done,
    input cfg_ready, start, mode, filt_len, stride_len, psum_mode, outbuf_ren,
    input pass_idx, busy, seq_done, err_timeout
  );
endinterface

// File: rtl/conv_pass_sequencer_watchdog.sv
// seq_watchdog: saturating RUN-cycle counter with terminal-count flag
// Ports: clk, rstn (async active-low), clr (zero the count), en (count this cycle),
//        tc (this enabled cycle is the (2^TMO_W-1)-th counted cycle, or later).
module seq_watchdog #(
  parameter int TMO_W = 16
) (
  input logic clk,
  input logic rstn,
  input logic clr,
  input logic en,
  output logic tc
);
  logic [TMO_W-1:0] cnt;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != '1) cnt <= cnt + TMO_W'(1);
  // cnt holds the number of earlier counted cycles, so cnt >= 2^TMO_W-2 marks the terminal cycle
  assign tc = en && (&cnt[TMO_W-1:1]);
endmodule

// File: rtl/conv_pass_sequencer.sv
// conv_pass_sequencer: multi-pass controller driving the convolution top from one layer config
// Ports: clk, rstn (async active-low), bus (conv_pass_sequencer_if.master): config handshake,
//        abort, FIFO flags and pass_done in; start/psum_mode/outbuf_ren, registered config,
//        pass_idx, busy, seq_done and err_timeout out.
module conv_pass_sequencer
  import conv_seq_pkg::*;
#(
  parameter int FILT_ADDR_LEN = FILT_ADDR_LEN_DEF,
  parameter int IF_ADDR_LEN = IF_ADDR_LEN_DEF,
  parameter int PASS_W = PASS_W_DEF,
  parameter int TMO_W = TMO_W_DEF
) (
  input logic clk,
  input logic rstn,
  conv_pass_sequencer_if.master bus
);
  seq_state_t state;
  logic [PASS_W-1:0] passes_q, pass_idx, idx_nxt;
  logic [FILT_ADDR_LEN-1:0] filt_q;
  logic [IF_ADDR_LEN-1:0] stride_q;
  logic [1:0] mode_q;
  logic acc_q, err_q, tc;
  seq_watchdog #(.TMO_W(TMO_W)) u_wdog (
    .clk(clk),
    .rstn(rstn),
    .clr(state == START),
    .en(state == RUN),
    .tc(tc)
  );
  assign idx_nxt = pass_idx + PASS_W'(1);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      passes_q <= '0;
      filt_q <= '0;
      stride_q <= '0;
      mode_q <= '0;
      acc_q <= 1'b0;
      pass_idx <= '0;
      err_q <= 1'b0;
    end else if (bus.abort && state != IDLE) state <= IDLE;
    else
      case (state)
        IDLE:
          if (bus.cfg_valid) begin
            passes_q <= bus.cfg_passes;
            filt_q <= bus.cfg_filt_len;
            stride_q <= bus.cfg_stride_len;
            mode_q <= bus.cfg_mode;
            acc_q <= bus.cfg_accumulate;
            pass_idx <= '0;
            err_q <= 1'b0;
            state <= bus.cfg_passes == '0 ? DONE : WAIT_DATA;
          end
        WAIT_DATA: if (!bus.if_empty && !bus.filter_empty) state <= START;
        START: state <= RUN;
        // pass_done takes priority over a coincident watchdog expiry
        RUN:
          if (bus.pass_done) state <= DRAIN;
          else if (tc) begin
            err_q <= 1'b1;
            state <= IDLE;
          end
        DRAIN: if (bus.outbuf_empty) state <= NEXT;
        NEXT: begin
          pass_idx <= idx_nxt;
          state <= idx_nxt == passes_q ? DONE : WAIT_DATA;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
  assign bus.cfg_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.start = state == START;
  assign bus.seq_done = state == DONE;
  assign bus.psum_mode = acc_q && pass_idx != '0 && (state inside {START, RUN, DRAIN});
  // the only input-dependent output: drain while data remains, relieve a full FIFO mid-pass
  assign bus.outbuf_ren = (state == DRAIN && !bus.outbuf_empty) || (state == RUN && bus.outbuf_full);
  assign bus.mode = mode_q;
  assign bus.filt_len = filt_q;
  assign bus.stride_len = stride_q;
  assign bus.pass_idx = pass_idx;
  assign bus.err_timeout = err_q;
endmodule
